vram_wr_arbiter: RTL and testbench

VRAM_WR_ARBITER -- requirements
Module: vram_wr_arbiter

---
 rtl/vram_wr_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_vram_wr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: merges host direct pixel writes with a rectangle-fill
// engine onto a single registered framebuffer write port.
// Host writes always win; the fill engine stalls in any host cycle.
// Optional build macro: FILL_CLIP_EN -- when defined, fill pixels that fall
// outside SCREEN_W x SCREEN_H still use their FILL cycle but are not written.
// fsm_state is a debug view of the fill FSM (0=IDLE, 1=FILL, 2=DONE).
module vram_wr_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 100
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        host_wr,
  input  logic [31:0] host_addr,
  input  logic [7:0]  host_data,
  input  logic        fill_start,
  input  logic [7:0]  fill_x,
  input  logic [7:0]  fill_y,
  input  logic [7:0]  fill_w,
  input  logic [7:0]  fill_h,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        cpu_wr,
  output logic [31:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] SW = 32'(SCREEN_W);
  localparam logic [31:0] SH = 32'(SCREEN_H);

  state_t      state_q, state_d;
  logic        fill_busy_q, fill_busy_d;
  logic        fill_done_q, fill_done_d;
  logic        cpu_wr_q, cpu_wr_d;
  logic [31:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]  cpu_data_q, cpu_data_d;

  // Latched rectangle parameters.
  logic [7:0]  x_q, x_d;
  logic [7:0]  w_q, w_d;
  logic [7:0]  h_q, h_d;
  logic [7:0]  color_q, color_d;

  // Walk position: offsets within the rectangle plus absolute col/row.
  // col/row are 9 bits so x+w-1 / y+h-1 never wrap.
  logic [7:0]  cnt_c_q, cnt_c_d;
  logic [7:0]  cnt_r_q, cnt_r_d;
  logic [8:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic [31:0] row_base_q, row_base_d;

  logic        pix_en;
  logic [31:0] pix_addr;

  // Current fill pixel address and whether it may be written.
  always_comb begin
    pix_addr = row_base_q + {23'd0, col_q};
`ifdef FILL_CLIP_EN
    pix_en = ({23'd0, col_q} < SW) && ({23'd0, row_q} < SH);
`else
    pix_en = 1'b1;
`endif
  end

  // Next-state: host grant, fill FSM sequencing and the raster walk.
  always_comb begin
    state_d     = state_q;
    fill_busy_d = fill_busy_q;
    fill_done_d = 1'b0;
    cpu_wr_d    = 1'b0;
    cpu_addr_d  = cpu_addr_q;
    cpu_data_d  = cpu_data_q;
    x_d         = x_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    cnt_c_d     = cnt_c_q;
    cnt_r_d     = cnt_r_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;

    // Host request owns the write port in its own cycle, in every state.
    if (host_wr) begin
      cpu_wr_d   = 1'b1;
      cpu_addr_d = host_addr;
      cpu_data_d = host_data;
    end

    case (state_q)
      IDLE: begin
        fill_busy_d = 1'b0;
        if (fill_start) begin
          x_d     = fill_x;
          w_d     = fill_w;
          h_d     = fill_h;
          color_d = fill_color;
          cnt_c_d = 8'd0;
          cnt_r_d = 8'd0;
          col_d   = {1'b0, fill_x};
          row_d   = {1'b0, fill_y};
          // One multiply per fill; rows then advance by adding SCREEN_W.
          row_base_d = {24'd0, fill_y} * SW;
          if ((fill_w != 8'd0) && (fill_h != 8'd0)) begin
            state_d     = FILL;
            fill_busy_d = 1'b1;
          end else begin
            state_d     = DONE;
            fill_done_d = 1'b1;
          end
        end
      end

      FILL: begin
        if (!host_wr) begin
          if (pix_en) begin
            cpu_wr_d   = 1'b1;
            cpu_addr_d = pix_addr;
            cpu_data_d = color_q;
          end
          if (cnt_c_q == w_q - 8'd1) begin
            cnt_c_d = 8'd0;
            col_d   = {1'b0, x_q};
            if (cnt_r_q == h_q - 8'd1) begin
              state_d     = DONE;
              fill_busy_d = 1'b0;
              fill_done_d = 1'b1;
            end else begin
              cnt_r_d    = cnt_r_q + 8'd1;
              row_d      = row_q + 9'd1;
              row_base_d = row_base_q + SW;
            end
          end else begin
            cnt_c_d = cnt_c_q + 8'd1;
            col_d   = col_q + 9'd1;
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        fill_busy_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        fill_busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any fill immediately.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      cpu_wr_q    <= 1'b0;
      cpu_addr_q  <= 32'd0;
      cpu_data_q  <= 8'd0;
      x_q         <= 8'd0;
      w_q         <= 8'd0;
      h_q         <= 8'd0;
      color_q     <= 8'd0;
      cnt_c_q     <= 8'd0;
      cnt_r_q     <= 8'd0;
      col_q       <= 9'd0;
      row_q       <= 9'd0;
      row_base_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
      cpu_wr_q    <= cpu_wr_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_data_q  <= cpu_data_d;
      x_q         <= x_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      cnt_c_q     <= cnt_c_d;
      cnt_r_q     <= cnt_r_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
    end
  end

  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;
  assign cpu_wr    = cpu_wr_q;
  assign cpu_addr  = cpu_addr_q;
  assign cpu_data  = cpu_data_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter; outputs are sampled 1 time unit
// after each rising edge.
module tb_vram_wr_arbiter;

  logic        cpu_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        host_wr = 1'b0;
  logic [31:0] host_addr = 32'd0;
  logic [7:0]  host_data = 8'd0;
  logic        fill_start = 1'b0;
  logic [7:0]  fill_x = 8'd0, fill_y = 8'd0, fill_w = 8'd0, fill_h = 8'd0;
  logic [7:0]  fill_color = 8'd0;
  logic        fill_busy, fill_done, cpu_wr;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int errors  = 0;

  vram_wr_arbiter #(.SCREEN_W(160), .SCREEN_H(100)) dut (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_data (host_data),
    .fill_start(fill_start),
    .fill_x    (fill_x),
    .fill_y    (fill_y),
    .fill_w    (fill_w),
    .fill_h    (fill_h),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .fsm_state (fsm_state)
  );

  // Clock generation.
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the full output set.
  task automatic step(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [7:0] data, input logic busy, input logic done);
    tick;
    chk({tag, "_wr"}, 32'(cpu_wr), 32'(wr));
    chk({tag, "_addr"}, cpu_addr, addr);
    chk({tag, "_data"}, 32'(cpu_data), 32'(data));
    chk({tag, "_busy"}, 32'(fill_busy), 32'(busy));
    chk({tag, "_done"}, 32'(fill_done), 32'(done));
  endtask

  task automatic set_fill(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                          input logic [7:0] h, input logic [7:0] c);
    fill_x = x; fill_y = y; fill_w = w; fill_h = h; fill_color = c;
  endtask

  logic [31:0] ea [8];

  initial begin
    // Reset state.
    tick;
    chk("rst_wr", 32'(cpu_wr), 32'd0);
    chk("rst_addr", cpu_addr, 32'd0);
    chk("rst_data", 32'(cpu_data), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    tick;
    reset = 1'b0;
    tick;

    // Basic 3x2 fill at (2,3): 482..484, 642..644.
    ea[0] = 482; ea[1] = 483; ea[2] = 484; ea[3] = 642; ea[4] = 643; ea[5] = 644;
    set_fill(8'd2, 8'd3, 8'd3, 8'd2, 8'hE0);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    chk("t1_busy0", 32'(fill_busy), 32'd1);
    chk("t1_wr0", 32'(cpu_wr), 32'd0);
    chk("t1_state", 32'(fsm_state), 32'd1);
    for (int i = 0; i < 6; i++)
      step($sformatf("t1_px%0d", i), 1'b1, ea[i], 8'hE0, (i != 5), (i == 5));
    step("t1_after", 1'b0, 32'd644, 8'hE0, 1'b0, 1'b0);

    // Same fill with a host write on the 3rd fill cycle.
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    step("t2_px0", 1'b1, 32'd482, 8'hE0, 1'b1, 1'b0);
    step("t2_px1", 1'b1, 32'd483, 8'hE0, 1'b1, 1'b0);
    host_wr = 1'b1; host_addr = 32'd5; host_data = 8'h1C;
    step("t2_host", 1'b1, 32'd5, 8'h1C, 1'b1, 1'b0);
    host_wr = 1'b0;
    step("t2_px2", 1'b1, 32'd484, 8'hE0, 1'b1, 1'b0);
    step("t2_px3", 1'b1, 32'd642, 8'hE0, 1'b1, 1'b0);
    step("t2_px4", 1'b1, 32'd643, 8'hE0, 1'b1, 1'b0);
    step("t2_px5", 1'b1, 32'd644, 8'hE0, 1'b0, 1'b1);
    step("t2_after", 1'b0, 32'd644, 8'hE0, 1'b0, 1'b0);

    // Zero-width fill: straight to DONE, no writes.
    set_fill(8'd7, 8'd7, 8'd0, 8'd4, 8'h11);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    chk("t3_done", 32'(fill_done), 32'd1);
    chk("t3_busy", 32'(fill_busy), 32'd0);
    chk("t3_wr", 32'(cpu_wr), 32'd0);
    step("t3_after", 1'b0, 32'd644, 8'hE0, 1'b0, 1'b0);

    // Fill crossing the right and bottom edges.
    set_fill(8'd158, 8'd99, 8'd4, 8'd2, 8'h5A);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
`ifdef FILL_CLIP_EN
    step("t4_px0", 1'b1, 32'd15998, 8'h5A, 1'b1, 1'b0);
    step("t4_px1", 1'b1, 32'd15999, 8'h5A, 1'b1, 1'b0);
    for (int i = 2; i < 8; i++)
      step($sformatf("t4_clip%0d", i), 1'b0, 32'd15999, 8'h5A, (i != 7), (i == 7));
`else
    ea[0] = 15998; ea[1] = 15999; ea[2] = 16000; ea[3] = 16001;
    ea[4] = 16158; ea[5] = 16159; ea[6] = 16160; ea[7] = 16161;
    for (int i = 0; i < 8; i++)
      step($sformatf("t4_px%0d", i), 1'b1, ea[i], 8'h5A, (i != 7), (i == 7));
`endif
    tick;

    // Reset in the middle of a 4x4 fill at (1,1).
    set_fill(8'd1, 8'd1, 8'd4, 8'd4, 8'h33);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    step("t5_px0", 1'b1, 32'd161, 8'h33, 1'b1, 1'b0);
    step("t5_px1", 1'b1, 32'd162, 8'h33, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_async_wr", 32'(cpu_wr), 32'd0);
    chk("t5_async_addr", cpu_addr, 32'd0);
    chk("t5_async_busy", 32'(fill_busy), 32'd0);
    chk("t5_async_state", 32'(fsm_state), 32'd0);
    step("t5_hold", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    set_fill(8'd10, 8'd0, 8'd1, 8'd1, 8'h77);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    chk("t5_new_busy", 32'(fill_busy), 32'd1);
    chk("t5_new_wr0", 32'(cpu_wr), 32'd0);
    step("t5_new_px", 1'b1, 32'd10, 8'h77, 1'b0, 1'b1);
    step("t5_new_after", 1'b0, 32'd10, 8'h77, 1'b0, 1'b0);

    // fill_start with other coordinates during FILL is ignored.
    ea[0] = 482; ea[1] = 483; ea[2] = 484; ea[3] = 642; ea[4] = 643; ea[5] = 644;
    set_fill(8'd2, 8'd3, 8'd3, 8'd2, 8'hE0);
    fill_start = 1'b1;
    tick;
    set_fill(8'd50, 8'd20, 8'd9, 8'd9, 8'h0F);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("t6_px%0d", i), 1'b1, ea[i], 8'hE0, (i != 5), (i == 5));
      fill_start = 1'b0;
    end
    step("t6_after", 1'b0, 32'd644, 8'hE0, 1'b0, 1'b0);
    chk("t6_state", 32'(fsm_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
